// File: rtl/lsu_mem_stage.sv
// Purpose: multi-cycle load/store unit that runs one request/response transaction per op on a 64-bit data-memory port.
// Latency: 3 cycles best case (accept -> REQ -> WAIT -> DONE); fault ops finish in 1 cycle with no memory request.
// Backpressure: in_ready only in IDLE; the request is held stable while mem_req_ready is low.
//
// Ports:
//   clk, rst                       core clock, asynchronous active-high reset
//   in_valid/in_ready              op handshake from execute (mem_ctrl, addr, wdata)
//   mem_req_*                      aligned 8-byte request: addr, we, lane-shifted wdata, byte strobes
//   mem_resp_valid/mem_resp_rdata  read data (loads) or write acknowledge (stores)
//   out_valid                      one-cycle completion pulse, qualifying out_rdata/out_misalign/out_illegal
module lsu_mem_stage #(
    parameter int XLEN   = 64,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mem_ctrl,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_we,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_misalign,
    output logic              out_illegal
);

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_LHU = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LH  = 4'b0100;
    localparam logic [3:0] OP_SD  = 4'b1000;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0]      ctrl_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            misalign_q;
    logic            illegal_q;

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(input logic [3:0] c);
        case (c)
            OP_LD, OP_SD:          op_size = 2'd3;
            OP_LW, OP_SW:          op_size = 2'd2;
            OP_LH, OP_LHU, OP_SH:  op_size = 2'd1;
            default:               op_size = 2'd0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [3:0] c);
        case (c)
            OP_LD, OP_LHU, OP_LBU, OP_LW, OP_LH,
            OP_SD, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
            default:                    op_legal = 1'b0;
        endcase
    endfunction

    // Decode of the incoming op, used only on the accept cycle
    logic       in_illegal;
    logic       in_misalign;
    logic [1:0] in_size;

    always_comb begin
        in_size     = op_size(mem_ctrl);
        in_illegal  = ~op_legal(mem_ctrl);
        in_misalign = 1'b0;
        case (in_size)
            2'd1:    in_misalign = addr[0];
            2'd2:    in_misalign = |addr[1:0];
            2'd3:    in_misalign = |addr[2:0];
            default: in_misalign = 1'b0;
        endcase
    end

    logic fault_now;
    assign fault_now = in_illegal | in_misalign;

    // Decode of the latched op, driving the request and the load formatter
    logic [1:0] q_size;
    logic       q_signed;
    logic       q_store;
    logic [5:0] lane_sh;

    assign q_size   = op_size(ctrl_q);
    assign q_signed = (ctrl_q == OP_LH) || (ctrl_q == OP_LW);
    assign q_store  = ctrl_q[3];
    assign lane_sh  = {addr_q[2:0], 3'b000};

    logic [MASK_W-1:0] mask_base;

    always_comb begin
        mask_base = '0;
        case (q_size)
            2'd0:    mask_base = MASK_W'(8'h01);
            2'd1:    mask_base = MASK_W'(8'h03);
            2'd2:    mask_base = MASK_W'(8'h0F);
            default: mask_base = '1;
        endcase
    end

    // Request outputs are gated by state so they read 0 outside REQ,
    // which also makes them drop immediately on an asynchronous reset.
    logic req_active;
    assign req_active    = (state_q == S_REQ);
    assign mem_req_valid = req_active;
    assign mem_req_addr  = req_active ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign mem_req_we    = req_active & q_store;
    assign mem_req_wdata = req_active ? (wdata_q << lane_sh) : '0;
    assign mem_req_wmask = (req_active & q_store) ? (mask_base << addr_q[2:0]) : '0;

    // Load formatting: pull the addressed lane down to bit 0, then extend
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_val;

    always_comb begin
        lane     = mem_resp_rdata >> lane_sh;
        load_val = lane;
        case (q_size)
            2'd0:    load_val = {{(XLEN-8){q_signed & lane[7]}}, lane[7:0]};
            2'd1:    load_val = {{(XLEN-16){q_signed & lane[15]}}, lane[15:0]};
            2'd2:    load_val = {{(XLEN-32){q_signed & lane[31]}}, lane[31:0]};
            default: load_val = lane;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = fault_now ? S_DONE : S_REQ;
            S_REQ:   if (mem_req_ready) state_d = S_WAIT;
            S_WAIT:  if (mem_resp_valid) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch on accept; result and flags only change on entry to DONE
    // so they stay readable until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && in_valid) begin
                ctrl_q  <= mem_ctrl;
                addr_q  <= addr;
                wdata_q <= wdata;
                if (fault_now) begin
                    rdata_q    <= '0;
                    illegal_q  <= in_illegal;
                    misalign_q <= ~in_illegal & in_misalign;
                end
            end
            if (state_q == S_WAIT && mem_resp_valid) begin
                rdata_q    <= q_store ? '0 : load_val;
                illegal_q  <= 1'b0;
                misalign_q <= 1'b0;
            end
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_rdata    = rdata_q;
    assign out_misalign = misalign_q;
    assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Purpose: self-checking bench for lsu_mem_stage with a byte-level reference model and a memory responder.
// Latency: checks out_valid cycle against 3 + request stall + response delay (1 for faults).
// Backpressure: responder stalls mem_req_ready and delays responses randomly.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mem_ctrl;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        out_valid;
    logic [63:0] out_rdata;
    logic        out_misalign;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.XLEN(64), .MASK_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_ctrl       (mem_ctrl),
        .addr           (addr),
        .wdata          (wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_rdata      (out_rdata),
        .out_misalign   (out_misalign),
        .out_illegal    (out_illegal)
    );

    // Every output except in_ready, concatenated for "all zero" checks
    logic [204:0] outs;
    assign outs = {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
                   out_valid, out_rdata, out_misalign, out_illegal};

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [3:0] c);
        case (c)
            4'b0000, 4'b1000:          return 8;
            4'b0011, 4'b1011:          return 4;
            4'b0001, 4'b0100, 4'b1010: return 2;
            4'b0010, 4'b1001:          return 1;
            default:                   return 0;
        endcase
    endfunction

    function automatic bit m_signed(input logic [3:0] c);
        return (c == 4'b0100) || (c == 4'b0011);
    endfunction

    function automatic bit m_mis(input logic [3:0] c, input logic [63:0] a);
        int n = m_size(c);
        int off = int'(a[2:0]);
        return (n != 0) && ((off % n) != 0);
    endfunction

    function automatic logic [63:0] m_load(input logic [3:0] c, input logic [63:0] a, input logic [63:0] rd);
        int n = m_size(c);
        int off = int'(a[2:0]);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
        if (m_signed(c) && r[8*n-1])
            for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [7:0] m_wmask(input logic [3:0] c, input logic [63:0] a);
        int n = m_size(c);
        int off = int'(a[2:0]);
        logic [7:0] m = '0;
        for (int i = off; i < off + n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] wd);
        int off = int'(a[2:0]);
        logic [63:0] r = '0;
        for (int i = off; i < 8; i++) r[8*i +: 8] = wd[8*(i-off) +: 8];
        return r;
    endfunction

    // ---------------- driver / responder observations ----------------
    int          o_nreq, o_nvalid, o_vcyc;
    bit          o_unstable, o_rdy_busy, o_rdy_after, o_rdy_start, o_hold, o_timeout;
    logic [63:0] o_req_addr, o_req_wdata, o_rdata;
    logic [7:0]  o_req_wmask;
    logic        o_req_we, o_mis, o_ill;

    // Runs one op: request stalled for 'stall' cycles, response 'delay' cycles after
    // acceptance. With 'junk', ignored traffic is injected (in_valid while busy,
    // mem_resp_valid while the request is still pending).
    task automatic do_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input int stall, input int delay, input bit junk);
        int cyc, acc_at, stall_left;
        bit resp_done;
        o_nreq = 0; o_nvalid = 0; o_vcyc = -1; o_unstable = 0; o_rdy_busy = 0;
        o_rdy_after = 0; o_hold = 0; o_timeout = 0;
        o_req_addr = '0; o_req_wdata = '0; o_req_wmask = '0; o_req_we = 0;
        o_rdata = '0; o_mis = 0; o_ill = 0;
        @(negedge clk);
        o_rdy_start = in_ready;
        in_valid = 1; mem_ctrl = c; addr = a; wdata = wd;
        @(posedge clk); #1;
        cyc = 1; acc_at = -1; stall_left = stall; resp_done = 0;
        while (1) begin
            in_valid = 0;
            mem_resp_valid = 0;
            mem_resp_rdata = {$urandom, $urandom};
            if (junk && o_nvalid == 0 && !out_valid) begin
                in_valid = 1; mem_ctrl = 4'($urandom); addr = {$urandom, $urandom};
            end
            if (junk && mem_req_valid) mem_resp_valid = 1;
            if (acc_at >= 0 && !resp_done && cyc == acc_at + 1 + delay) begin
                mem_resp_valid = 1; mem_resp_rdata = rd; resp_done = 1;
            end
            mem_req_ready = 1'($urandom_range(0, 1));
            if (mem_req_valid) begin
                if (o_nreq == 0) begin
                    o_req_addr = mem_req_addr; o_req_wdata = mem_req_wdata;
                    o_req_wmask = mem_req_wmask; o_req_we = mem_req_we;
                end else if (mem_req_addr !== o_req_addr || mem_req_wdata !== o_req_wdata ||
                             mem_req_wmask !== o_req_wmask || mem_req_we !== o_req_we) begin
                    o_unstable = 1;
                end
                o_nreq++;
                if (stall_left == 0) begin mem_req_ready = 1; acc_at = cyc; end
                else begin mem_req_ready = 0; stall_left--; end
            end
            if (o_nvalid == 0 && in_ready) o_rdy_busy = 1;
            if (out_valid) begin
                o_nvalid++;
                if (o_vcyc < 0) begin
                    o_vcyc = cyc; o_rdata = out_rdata; o_mis = out_misalign; o_ill = out_illegal;
                end
            end
            if (o_vcyc >= 0 && cyc == o_vcyc + 1) begin
                o_rdy_after = in_ready;
                o_hold = (out_rdata === o_rdata) && (out_misalign === o_mis) && (out_illegal === o_ill);
            end
            if (o_vcyc >= 0 && cyc >= o_vcyc + 2) break;
            if (cyc >= 100) begin o_timeout = 1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit saw_v, saw_busy;
        repeat (2) @(posedge clk);
        #1;
        total++; if (outs !== '0) begin bad++; $display("FAIL reset_outs got=%h want=0", outs); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        // stale response right after reset must be ignored
        @(negedge clk); rst = 0; mem_resp_valid = 1; mem_resp_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        saw_v = 0; saw_busy = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) saw_v = 1;
            if (!in_ready) saw_busy = 1;
        end
        mem_resp_valid = 0;
        total++; if (saw_v !== 0) begin bad++; $display("FAIL stale_resp_valid got=%b want=0", saw_v); end
        total++; if (saw_busy !== 0) begin bad++; $display("FAIL stale_resp_ready got=%b want=0", saw_busy); end
    endtask

    task automatic test_lh();
        do_op(4'b0100, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 0, 0, 0);
        total++; if (o_rdy_start !== 1'b1) begin bad++; $display("FAIL lh_in_ready got=%b want=1", o_rdy_start); end
        total++; if (o_vcyc !== 3) begin bad++; $display("FAIL lh_latency got=%0d want=3", o_vcyc); end
        total++; if (o_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin bad++; $display("FAIL lh_rdata got=%h want=ffffffffffff8001", o_rdata); end
        total++; if (o_req_wmask !== 8'h00 || o_req_we !== 1'b0) begin bad++; $display("FAIL lh_req_load got=%h/%b want=00/0", o_req_wmask, o_req_we); end
        total++; if (o_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL lh_req_addr got=%h want=80000000", o_req_addr); end
    endtask

    task automatic test_sb();
        do_op(4'b1001, 64'h8000_0003, 64'hAB, 64'hDEAD_BEEF_DEAD_BEEF, 1, 1, 0);
        total++; if (o_req_wmask !== 8'h08) begin bad++; $display("FAIL sb_wmask got=%h want=08", o_req_wmask); end
        total++; if (o_req_wdata !== 64'h0000_0000_AB00_0000) begin bad++; $display("FAIL sb_wdata got=%h want=ab000000", o_req_wdata); end
        total++; if (o_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL sb_addr got=%h want=80000000", o_req_addr); end
        total++; if (o_req_we !== 1'b1) begin bad++; $display("FAIL sb_we got=%b want=1", o_req_we); end
        total++; if (o_nvalid !== 1 || o_rdata !== 64'h0) begin bad++; $display("FAIL sb_done got=%0d/%h want=1/0", o_nvalid, o_rdata); end
        total++; if (o_vcyc !== 5) begin bad++; $display("FAIL sb_latency got=%0d want=5", o_vcyc); end
    endtask

    task automatic test_misalign();
        do_op(4'b0011, 64'h8000_0002, 64'h0, 64'h1234, 0, 0, 0);
        total++; if (o_nreq !== 0) begin bad++; $display("FAIL lw_mis_req got=%0d want=0", o_nreq); end
        total++; if (o_vcyc !== 1) begin bad++; $display("FAIL lw_mis_latency got=%0d want=1", o_vcyc); end
        total++; if (o_mis !== 1'b1 || o_ill !== 1'b0) begin bad++; $display("FAIL lw_mis_flags got=%b%b want=10", o_mis, o_ill); end
        total++; if (o_rdata !== 64'h0) begin bad++; $display("FAIL lw_mis_rdata got=%h want=0", o_rdata); end
    endtask

    task automatic test_illegal();
        do_op(4'b0110, 64'h8000_0003, 64'h0, 64'h1234, 0, 0, 0);
        total++; if (o_nreq !== 0) begin bad++; $display("FAIL ill_req got=%0d want=0", o_nreq); end
        total++; if (o_ill !== 1'b1 || o_mis !== 1'b0) begin bad++; $display("FAIL ill_flags got=ill%b mis%b want=ill1 mis0", o_ill, o_mis); end
        total++; if (o_vcyc !== 1 || o_hold !== 1'b1) begin bad++; $display("FAIL ill_timing got=%0d/%b want=1/1", o_vcyc, o_hold); end
    endtask

    task automatic test_ld_stall();
        do_op(4'b0000, 64'h8000_1238, 64'h0, 64'h1122_3344_5566_7788, 5, 0, 0);
        total++; if (o_unstable !== 1'b0) begin bad++; $display("FAIL ld_stall_stable got=%b want=0", o_unstable); end
        total++; if (o_nreq !== 6) begin bad++; $display("FAIL ld_stall_reqcycles got=%0d want=6", o_nreq); end
        total++; if (o_nvalid !== 1) begin bad++; $display("FAIL ld_stall_pulses got=%0d want=1", o_nvalid); end
        total++; if (o_rdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL ld_stall_rdata got=%h want=1122334455667788", o_rdata); end
        total++; if (o_req_addr !== 64'h8000_1238) begin bad++; $display("FAIL ld_stall_addr got=%h want=80001238", o_req_addr); end
    endtask

    task automatic test_reset_abort();
        bit saw_v, saw_busy;
        logic [63:0] rd;
        // abort while in REQ
        @(negedge clk); in_valid = 1; mem_ctrl = 4'b0000; addr = 64'h8000_0010; wdata = '0;
        @(posedge clk); #1; in_valid = 0; mem_req_ready = 0;
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL abort_req_pre got=%b want=1", mem_req_valid); end
        #2 rst = 1; #1;
        total++; if (outs !== '0 || in_ready !== 1'b1) begin bad++; $display("FAIL abort_req_outs got=%h rdy=%b want=0 rdy=1", outs, in_ready); end
        @(negedge clk); rst = 0;
        // abort while in WAIT, then a late response
        @(negedge clk); in_valid = 1; mem_ctrl = 4'b0000; addr = 64'h8000_0020;
        @(posedge clk); #1; in_valid = 0; mem_req_ready = 1;
        @(posedge clk); #1; mem_req_ready = 0;
        #2 rst = 1; #1;
        total++; if (outs !== '0 || in_ready !== 1'b1) begin bad++; $display("FAIL abort_wait_outs got=%h rdy=%b want=0 rdy=1", outs, in_ready); end
        @(negedge clk); rst = 0; mem_resp_valid = 1; mem_resp_rdata = 64'hCAFE_F00D_1234_5678;
        saw_v = 0; saw_busy = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) saw_v = 1;
            if (!in_ready) saw_busy = 1;
        end
        mem_resp_valid = 0;
        total++; if (saw_v !== 0 || saw_busy !== 0) begin bad++; $display("FAIL abort_late_resp got=v%b busy%b want=v0 busy0", saw_v, saw_busy); end
        rd = {$urandom, $urandom};
        do_op(4'b0010, 64'h0000_0000_8000_0005, 64'h0, rd, 0, 0, 0);
        total++; if (o_rdata !== {56'h0, rd[47:40]}) begin bad++; $display("FAIL abort_lbu_rdata got=%h want=%h", o_rdata, {56'h0, rd[47:40]}); end
        total++; if (o_vcyc !== 3) begin bad++; $display("FAIL abort_lbu_latency got=%0d want=3", o_vcyc); end
    endtask

    task automatic test_random();
        logic [3:0]  legal [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
        logic [3:0]  c;
        logic [63:0] a, wd, rd, exp_rd;
        int n, stall, delay, exp_cyc;
        bit junk, fault;
        for (int k = 0; k < 40; k++) begin
            c = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal[$urandom_range(0, 8)];
            n = m_size(c);
            a = {$urandom, $urandom};
            if (n > 0 && $urandom_range(0, 2) != 0) a[2:0] = 3'((int'(a[2:0]) / n) * n);
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            stall = $urandom_range(0, 3);
            delay = $urandom_range(0, 3);
            junk  = 1'($urandom_range(0, 1));
            do_op(c, a, wd, rd, stall, delay, junk);
            fault   = (n == 0) || m_mis(c, a);
            exp_cyc = fault ? 1 : 3 + stall + delay;
            exp_rd  = (fault || c[3]) ? 64'h0 : m_load(c, a, rd);
            total++; if (o_timeout !== 1'b0 || o_nvalid !== 1) begin bad++; $display("FAIL rnd%0d_done got=to%b n%0d want=to0 n1", k, o_timeout, o_nvalid); end
            total++; if (o_vcyc !== exp_cyc) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", k, o_vcyc, exp_cyc); end
            total++; if (o_rdata !== exp_rd) begin bad++; $display("FAIL rnd%0d_rdata ctrl=%h addr=%h got=%h want=%h", k, c, a, o_rdata, exp_rd); end
            total++; if (o_ill !== (n == 0) || o_mis !== (n != 0 && m_mis(c, a))) begin bad++; $display("FAIL rnd%0d_flags got=ill%b mis%b", k, o_ill, o_mis); end
            total++; if (o_nreq !== (fault ? 0 : stall + 1) || o_unstable !== 1'b0) begin bad++; $display("FAIL rnd%0d_req got=%0d unst=%b want=%0d", k, o_nreq, o_unstable, fault ? 0 : stall + 1); end
            total++; if (o_rdy_busy !== 1'b0 || o_rdy_after !== 1'b1 || o_hold !== 1'b1) begin bad++; $display("FAIL rnd%0d_handshake got=busy%b after%b hold%b", k, o_rdy_busy, o_rdy_after, o_hold); end
            if (!fault) begin
                total++; if (o_req_addr !== {a[63:3], 3'b000}) begin bad++; $display("FAIL rnd%0d_addr got=%h want=%h", k, o_req_addr, {a[63:3], 3'b000}); end
                total++; if (o_req_we !== c[3] || o_req_wmask !== (c[3] ? m_wmask(c, a) : 8'h00)) begin bad++; $display("FAIL rnd%0d_mask got=we%b %h", k, o_req_we, o_req_wmask); end
                if (c[3]) begin
                    total++; if (o_req_wdata !== m_wdata(a, wd)) begin bad++; $display("FAIL rnd%0d_wdata got=%h want=%h", k, o_req_wdata, m_wdata(a, wd)); end
                end
            end
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; mem_ctrl = '0; addr = '0; wdata = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
        test_reset();
        test_lh();
        test_sb();
        test_misalign();
        test_ld_stall();
        test_illegal();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
